// File: rtl/hub75_framebuf.sv
// Double-buffered 32x32 RGB frame store: raster stream fills the back bank, two registered read ports scan the front bank.
// Read latency 1 cycle; s_ready drops once a frame is complete until frame_end swaps banks. `HUB75_FB_PATTERN_EN: colour bars until first swap.
module hub75_framebuf #(
    parameter int FRAME_W = 32,
    parameter int FRAME_H = 32,
    parameter int PIX_W   = 3,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    input  logic              frame_end,
    input  logic [ADDR_W-1:0] rd_addr_top,
    input  logic [ADDR_W-1:0] rd_addr_bot,
    output logic [PIX_W-1:0]  rd_data_top,
    output logic [PIX_W-1:0]  rd_data_bot,
    output logic              swap,
    output logic              sync_err
);

    localparam int N = FRAME_W * FRAME_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt, w_wr_addr;
    logic              w_wr_en, w_swap_nxt, w_sync_err_nxt, w_xfer;
    logic              r_front, r_rdy, r_swap, r_sync_err;
    logic [PIX_W-1:0]  r_mem0 [0:N-1];
    logic [PIX_W-1:0]  r_mem1 [0:N-1];
    logic [PIX_W-1:0]  r_rd_top, r_rd_bot;
    logic [PIX_W-1:0]  w_top_src, w_bot_src;
    logic              w_top_oor, w_bot_oor;

    assign w_xfer      = s_valid && r_rdy;
    assign s_ready     = r_rdy;
    assign swap        = r_swap;
    assign sync_err    = r_sync_err;
    assign rd_data_top = r_rd_top;
    assign rd_data_bot = r_rd_bot;

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_wr_addr      = r_wr_ptr;
        w_wr_en        = 1'b0;
        w_swap_nxt     = 1'b0;
        w_sync_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && s_sof) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = '0;
                    w_wr_ptr_nxt = ONE;
                    w_state_nxt  = FILL;
                end
            end
            FILL: begin
                if (w_xfer) begin
                    w_wr_en = 1'b1;
                    if (s_sof) begin
                        w_wr_addr      = '0;
                        w_wr_ptr_nxt   = ONE;
                        w_sync_err_nxt = 1'b1;
                    end else if (r_wr_ptr == LAST) begin
                        // explicit wrap: N may equal 2**ADDR_W
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = FULL;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + ONE;
                    end
                end
            end
            FULL: begin
                if (frame_end) begin
                    w_swap_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_front    <= 1'b0;
            r_rdy      <= 1'b0;
            r_swap     <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_front    <= r_front ^ w_swap_nxt;
            r_rdy      <= (w_state_nxt != FULL);
            r_swap     <= w_swap_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    // Writes always land in the back bank, so they never collide with scan reads.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (r_front) r_mem0[w_wr_addr] <= s_data;
            else         r_mem1[w_wr_addr] <= s_data;
        end
    end

    generate
        if (2**ADDR_W > N) begin : g_oor
            assign w_top_oor = (rd_addr_top >= ADDR_W'(N));
            assign w_bot_oor = (rd_addr_bot >= ADDR_W'(N));
        end else begin : g_no_oor
            assign w_top_oor = 1'b0;
            assign w_bot_oor = 1'b0;
        end
    endgenerate

`ifdef HUB75_FB_PATTERN_EN
    logic r_pat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_pat <= 1'b1;
        else if (w_swap_nxt) r_pat <= 1'b0;
    end

    assign w_top_src = r_pat ? PIX_W'(rd_addr_top[4:2])
                             : (r_front ? r_mem1[rd_addr_top] : r_mem0[rd_addr_top]);
    assign w_bot_src = r_pat ? PIX_W'(rd_addr_bot[4:2])
                             : (r_front ? r_mem1[rd_addr_bot] : r_mem0[rd_addr_bot]);
`else
    assign w_top_src = r_front ? r_mem1[rd_addr_top] : r_mem0[rd_addr_top];
    assign w_bot_src = r_front ? r_mem1[rd_addr_bot] : r_mem0[rd_addr_bot];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_top <= '0;
            r_rd_bot <= '0;
        end else begin
            r_rd_top <= w_top_oor ? '0 : w_top_src;
            r_rd_bot <= w_bot_oor ? '0 : w_bot_src;
        end
    end

endmodule
